// File: rtl/riscv_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, bubbles, flushes, redirects,
// EX operand forwarding and saturating stall/flush counters.
module riscv_hazard_ctrl #(
    parameter int REGFILE_COUNT = 32,
    parameter int CNT_WIDTH     = 32,
    parameter int MAX_WAIT      = 64,
    localparam int RW           = $clog2(REGFILE_COUNT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [RW-1:0]        rs1_ID_i,
    input  logic [RW-1:0]        rs2_ID_i,
    input  logic                 rs1_used_i,
    input  logic                 rs2_used_i,
    input  logic [RW-1:0]        rs1_EX_i,
    input  logic [RW-1:0]        rs2_EX_i,
    input  logic [RW-1:0]        rd_EX_i,
    input  logic                 reg_write_EX_i,
    input  logic                 mem_read_EX_i,
    input  logic [RW-1:0]        rd_MEM_i,
    input  logic                 reg_write_MEM_i,
    input  logic [RW-1:0]        rd_WB_i,
    input  logic                 reg_write_WB_i,
    input  logic                 branch_taken_i,
    input  logic                 mem_busy_i,
    input  logic                 cnt_clr_i,
    output logic                 stall_IF_o,
    output logic                 stall_ID_o,
    output logic                 stall_EX_o,
    output logic                 stall_MEM_o,
    output logic                 bubble_EX_o,
    output logic                 bubble_WB_o,
    output logic                 flush_ID_o,
    output logic                 flush_EX_o,
    output logic                 flush_MEM_o,
    output logic                 redirect_o,
    output logic [1:0]           fwd_a_sel_o,
    output logic [1:0]           fwd_b_sel_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [1:0]  FWD_RF  = 2'b00;
    localparam logic [1:0]  FWD_MEM = 2'b01;
    localparam logic [1:0]  FWD_WB  = 2'b10;
    localparam logic [15:0] MAX_W   = 16'(MAX_WAIT);
    localparam logic [RW-1:0] X0    = '0;

    state_t         state;
    state_t         state_nxt;
    logic           pending;
    logic           pending_nxt;
    logic [15:0]    wait_cnt;
    logic [15:0]    wait_cnt_nxt;
    logic           timeout;
    logic           timeout_nxt;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    logic lu;
    logic redir;
    logic sel_wait;
    logic sel_redir;
    logic sel_lu;

    function automatic logic [1:0] fwd_pick(
        input logic [RW-1:0] rs,
        input logic [RW-1:0] rd_mem,
        input logic          we_mem,
        input logic [RW-1:0] rd_wb,
        input logic          we_wb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_mem && rd_mem != X0 && rd_mem == rs) begin
            sel = FWD_MEM;
        end else if (we_wb && rd_wb != X0 && rd_wb == rs) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel_o = FWD_RF;
        fwd_b_sel_o = FWD_RF;
        if (!rst_i) begin
            fwd_a_sel_o = fwd_pick(rs1_EX_i, rd_MEM_i, reg_write_MEM_i,
                                   rd_WB_i, reg_write_WB_i);
            fwd_b_sel_o = fwd_pick(rs2_EX_i, rd_MEM_i, reg_write_MEM_i,
                                   rd_WB_i, reg_write_WB_i);
        end
    end

    assign lu = mem_read_EX_i && reg_write_EX_i && rd_EX_i != X0 &&
                ((rs1_used_i && rd_EX_i == rs1_ID_i) ||
                 (rs2_used_i && rd_EX_i == rs2_ID_i));

    assign redir = branch_taken_i || pending;

    // Mutually exclusive selects encode busy > redirect > load-use.
    assign sel_wait  = mem_busy_i;
    assign sel_redir = !mem_busy_i && redir;
    assign sel_lu    = !mem_busy_i && !redir && lu;

    always_comb begin
        stall_IF_o  = 1'b0;
        stall_ID_o  = 1'b0;
        stall_EX_o  = 1'b0;
        stall_MEM_o = 1'b0;
        bubble_EX_o = 1'b0;
        bubble_WB_o = 1'b0;
        flush_ID_o  = 1'b0;
        flush_EX_o  = 1'b0;
        flush_MEM_o = 1'b0;
        redirect_o  = 1'b0;
        if (!rst_i) begin
            unique case (1'b1)
                sel_wait: begin
                    stall_IF_o  = 1'b1;
                    stall_ID_o  = 1'b1;
                    stall_EX_o  = 1'b1;
                    stall_MEM_o = 1'b1;
                    bubble_WB_o = 1'b1;
                end
                sel_redir: begin
                    redirect_o  = 1'b1;
                    flush_ID_o  = 1'b1;
                    flush_EX_o  = 1'b1;
                    flush_MEM_o = 1'b1;
                end
                sel_lu: begin
                    stall_IF_o  = 1'b1;
                    stall_ID_o  = 1'b1;
                    bubble_EX_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:      if (mem_busy_i) state_nxt = MEM_WAIT;
            MEM_WAIT: if (!mem_busy_i) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        wait_cnt_nxt = 16'd0;
        if (mem_busy_i) begin
            wait_cnt_nxt = (&wait_cnt) ? wait_cnt : wait_cnt + 16'd1;
        end
    end

    always_comb begin
        pending_nxt = pending;
        if (mem_busy_i && branch_taken_i) begin
            pending_nxt = 1'b1;
        end else if (sel_redir) begin
            pending_nxt = 1'b0;
        end
    end

    // Sticky flag: only reset can clear it.
    assign timeout_nxt = timeout ||
                         (state_nxt == MEM_WAIT && wait_cnt_nxt >= MAX_W);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            pending  <= 1'b0;
            wait_cnt <= 16'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            wait_cnt <= wait_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_IF_o && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect_o && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign timeout_o   = timeout;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

endmodule
